// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: md_op codes, FSM states
// and the hilo_we write-enable patterns.
package hilo_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic [1:0] WE_HI   = 2'b10;
  localparam logic [1:0] WE_LO   = 2'b01;
  localparam logic [1:0] WE_BOTH = 2'b11;

  // Magnitude of a 32-bit operand; only negated when the op is signed.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_md_unit_div_iter.sv
// Unsigned restoring divider: one quotient bit per cycle over STEPS cycles.
// start_i loads operands, abort_i drops a running divide, done_o marks the last step.
module div_iter #(
  parameter int STEPS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  localparam int CW = $clog2(STEPS);

  logic          run_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   quo_q, rem_q, den_q;
  logic [32:0]   trial;
  logic          last;

  // Quotient register doubles as the dividend shift source.
  assign trial = {rem_q, quo_q[31]} - {1'b0, den_q};
  assign last  = (cnt_q == CW'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      den_q <= '0;
    end else if (abort_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      quo_q <= dividend_i;
      rem_q <= '0;
      den_q <= divisor_i;
    end else if (run_q) begin
      if (!trial[32]) begin
        rem_q <= trial[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= {rem_q[30:0], quo_q[31]};
        quo_q <= {quo_q[30:0], 1'b0};
      end
      cnt_q <= cnt_q + CW'(1);
      if (last) run_q <= 1'b0;
    end
  end

  assign done_o = run_q && last;
  assign quot_o = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/hilo_md_unit.sv
// HI/LO register owner: MTHI/MTLO, single-cycle MULT/MULTU and, when HILO_DIV_EN
// is defined, an iterative DIV/DIVU that stalls the pipeline while it runs.
module hilo_md_unit
  import hilo_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [1:0]  hilo_we,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_busy
);

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] prod_s, prod_u;
  logic        idle, accept, div_wr;
  logic [31:0] div_hi, div_lo;

  assign accept = op_valid && !flush && idle;
  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

`ifdef HILO_DIV_EN
  div_state_e  state_q, state_d;
  logic        div_busy_q, q_neg_q, r_neg_q;
  logic        signed_div, div_start, iter_abort, iter_done;
  logic [31:0] mag_a, mag_b, quot_mag, rem_mag;

  assign idle       = (state_q == IDLE);
  assign signed_div = (md_op == MD_DIV);
  assign div_start  = accept && (hilo_we == WE_BOTH) && (md_op == MD_DIV || md_op == MD_DIVU);
  assign iter_abort = flush && (state_q != IDLE);
  assign mag_a      = mag32(src_a, signed_div);
  assign mag_b      = mag32(src_b, signed_div);

  div_iter #(.STEPS(DIV_STEPS)) u_div_iter (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (div_start),
    .abort_i    (iter_abort),
    .dividend_i (mag_a),
    .divisor_i  (mag_b),
    .done_o     (iter_done),
    .quot_o     (quot_mag),
    .rem_o      (rem_mag)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (div_start) state_d = DIV_RUN;
      DIV_RUN:  if (flush) state_d = IDLE;
                else if (iter_done) state_d = DIV_DONE;
      DIV_DONE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Divide-by-zero keeps the all-ones quotient unsigned so LO reads 0xFFFFFFFF.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      div_busy_q <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_busy_q <= (state_d == DIV_RUN);
      if (div_start) begin
        q_neg_q <= signed_div && (src_a[31] ^ src_b[31]) && (src_b != 32'd0);
        r_neg_q <= signed_div && src_a[31];
      end
    end
  end

  assign stall    = (idle && div_start) || (state_q == DIV_RUN && !flush);
  assign div_busy = div_busy_q;
  assign div_wr   = (state_q == DIV_DONE) && !flush;
  assign div_lo   = q_neg_q ? (~quot_mag + 32'd1) : quot_mag;
  assign div_hi   = r_neg_q ? (~rem_mag + 32'd1) : rem_mag;
`else
  assign idle     = 1'b1;
  assign stall    = 1'b0;
  assign div_busy = 1'b0;
  assign div_wr   = 1'b0;
  assign div_hi   = '0;
  assign div_lo   = '0;
`endif

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_wr) begin
      hi_d = div_hi;
      lo_d = div_lo;
    end else if (accept) begin
      case (hilo_we)
        WE_HI:   hi_d = src_a;
        WE_LO:   lo_d = src_a;
        WE_BOTH: begin
          if (md_op == MD_MULT)       {hi_d, lo_d} = prod_s;
          else if (md_op == MD_MULTU) {hi_d, lo_d} = prod_u;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_md_unit.sv
// Self-checking bench for hilo_md_unit; divide expectations follow HILO_DIV_EN.
module tb_hilo_md_unit;
  import hilo_pkg::*;

`ifdef HILO_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int EXP_STALL = DIV_EN ? 33 : 0;
  localparam int EXP_BUSY  = DIV_EN ? 32 : 0;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  hilo_we = 2'b00;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        stall, div_busy;
  logic [31:0] hi_o, lo_o;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;
  logic [63:0] exp_q[$];

  hilo_md_unit #(.DIV_STEPS(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .op_valid(op_valid),
    .hilo_we(hilo_we), .md_op(md_op), .src_a(src_a), .src_b(src_b),
    .stall(stall), .hi_o(hi_o), .lo_o(lo_o), .div_busy(div_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input logic f, input logic [1:0] we,
                       input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = v; flush = f; hilo_we = we; md_op = op; src_a = a; src_b = b;
    #1;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 2'b00, MD_NONE, $urandom, $urandom);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint      sa, sb, sp;
    logic [63:0] ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sp = sa * sb;
      return sp;
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Returns {HI, LO}: HI is the remainder, LO the quotient.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  // Single-cycle ops only (MT and MULT); divides are modelled in their tests.
  task automatic ref_accept(input logic v, input logic f, input logic [1:0] we,
                            input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!v || f) return;
    if (we == 2'b10) mdl_hi = a;
    else if (we == 2'b01) mdl_lo = a;
    else if (we == 2'b11 && (op == MD_MULT || op == MD_MULTU))
      {mdl_hi, mdl_lo} = ref_mult(a, b, op == MD_MULT);
  endtask

  task automatic issue(input logic v, input logic f, input logic [1:0] we,
                       input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(v, f, we, op, a, b);
    ref_accept(v, f, we, op, a, b);
    exp_q.push_back({mdl_hi, mdl_lo});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    drive_idle();
    step();
    step();
    n_checks++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_hilo: hi/lo=%h/%h expected 0/0", hi_o, lo_o);
    end
    n_checks++;
    if (stall !== 1'b0 || div_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: stall/div_busy=%b/%b expected 0/0", stall, div_busy);
    end
    resetn = 1'b1;
    mdl_hi = '0;
    mdl_lo = '0;
    step();
  endtask

  task automatic test_mt();
    logic [63:0] e;
    issue(1'b1, 1'b0, 2'b10, MD_NONE, 32'h1234_5678, $urandom);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL mthi_stall: stall=%b expected 0", stall); end
    step();
    issue(1'b1, 1'b0, 2'b01, MD_NONE, 32'h9ABC_DEF0, $urandom);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL mtlo_stall: stall=%b expected 0", stall); end
    e = exp_q.pop_front();
    n_checks++;
    if ({hi_o, lo_o} !== e) begin
      n_fail++;
      $display("FAIL mthi_value: hi/lo=%h/%h expected %h/%h", hi_o, lo_o, e[63:32], e[31:0]);
    end
    step();
    drive_idle();
    e = exp_q.pop_front();
    n_checks++;
    if ({hi_o, lo_o} !== {32'h1234_5678, 32'h9ABC_DEF0} || {hi_o, lo_o} !== e) begin
      n_fail++;
      $display("FAIL mtlo_value: hi/lo=%h/%h expected 12345678/9abcdef0", hi_o, lo_o);
    end
  endtask

  task automatic test_mult();
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [63:0] e;
    for (int i = 0; i < 26; i++) begin
      if (i < 2) begin
        a  = 32'hFFFF_FFFE;
        b  = 32'd3;
        op = (i == 0) ? MD_MULT : MD_MULTU;
      end else begin
        a  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
        b  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
        op = $urandom_range(0, 1) ? MD_MULT : MD_MULTU;
      end
      issue(1'b1, 1'b0, 2'b11, op, a, b);
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL mult_stall[%0d]: stall=%b expected 0", i, stall); end
      step();
      drive_idle();
      e = exp_q.pop_front();
      if (i == 0) e = {32'hFFFF_FFFF, 32'hFFFF_FFFA};
      if (i == 1) e = {32'h0000_0002, 32'hFFFF_FFFA};
      n_checks++;
      if ({hi_o, lo_o} !== e) begin
        n_fail++;
        $display("FAIL mult_value[%0d] op=%0d a=%h b=%h: hi/lo=%h/%h expected %h/%h",
                 i, op, a, b, hi_o, lo_o, e[63:32], e[31:0]);
      end
    end
  endtask

  // Random mix of MT, MULT, no-write patterns, invalid and flushed ops.
  task automatic test_random_ops();
    logic        v, f;
    logic [1:0]  we;
    logic [2:0]  op;
    logic [63:0] e;
    for (int i = 0; i < 40; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 5) == 0);
      we = 2'($urandom_range(0, 3));
      op = 3'($urandom_range(0, 7));
      if (we == 2'b11 && (op == MD_DIV || op == MD_DIVU)) op = MD_NONE;
      issue(v, f, we, op, $urandom, $urandom);
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL rand_stall[%0d]: stall=%b expected 0", i, stall); end
      step();
      e = exp_q.pop_front();
      n_checks++;
      if ({hi_o, lo_o} !== e) begin
        n_fail++;
        $display("FAIL rand_value[%0d] v=%b f=%b we=%b op=%0d: hi/lo=%h/%h expected %h/%h",
                 i, v, f, we, op, hi_o, lo_o, e[63:32], e[31:0]);
      end
    end
    drive_idle();
  endtask

  // Each divide is held presented until stall drops, retires, then an MTLO follows at once.
  task automatic test_div();
    logic [31:0] ta [0:4] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd5, 32'hFFFF_FFF7};
    logic [31:0] tb [0:4] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'd0};
    bit          ts [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] a, b, mt;
    bit          sgn;
    logic [63:0] e;
    int          n_st, n_busy;
    for (int i = 0; i < 11; i++) begin
      if (i < 5) begin
        a = ta[i]; b = tb[i]; sgn = ts[i];
      end else begin
        a   = $urandom;
        b   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
        sgn = $urandom_range(0, 1);
      end
      e = DIV_EN ? ref_div(a, b, sgn) : {mdl_hi, mdl_lo};
      if (i == 0 && DIV_EN) e = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
      if (i == 2 && DIV_EN) e = {32'h0000_0000, 32'h8000_0000};
      drive(1'b1, 1'b0, 2'b11, sgn ? MD_DIV : MD_DIVU, a, b);
      n_st = 0;
      n_busy = 0;
      while (stall === 1'b1 && n_st < 100) begin
        n_st++;
        if (div_busy === 1'b1) n_busy++;
        step();
        #1;
      end
      n_checks++;
      if (n_st != EXP_STALL) begin
        n_fail++;
        $display("FAIL div_stall_len[%0d]: %0d stall cycles expected %0d", i, n_st, EXP_STALL);
      end
      n_checks++;
      if (n_busy != EXP_BUSY || div_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL div_busy_len[%0d]: %0d busy cycles (now %b) expected %0d (now 0)",
                 i, n_busy, div_busy, EXP_BUSY);
      end
      step();
      mt = $urandom;
      drive(1'b1, 1'b0, 2'b01, MD_NONE, mt, $urandom);
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL div_restart[%0d]: stall=%b expected 0", i, stall); end
      n_checks++;
      if ({hi_o, lo_o} !== e) begin
        n_fail++;
        $display("FAIL div_value[%0d] sgn=%0d a=%h b=%h: hi/lo=%h/%h expected %h/%h",
                 i, sgn, a, b, hi_o, lo_o, e[63:32], e[31:0]);
      end
      {mdl_hi, mdl_lo} = e;
      step();
      drive_idle();
      mdl_lo = mt;
      n_checks++;
      if ({hi_o, lo_o} !== {mdl_hi, mdl_lo}) begin
        n_fail++;
        $display("FAIL div_b2b_mtlo[%0d]: hi/lo=%h/%h expected %h/%h", i, hi_o, lo_o, mdl_hi, mdl_lo);
      end
    end
  endtask

  task automatic test_flush_run();
    drive(1'b1, 1'b0, 2'b10, MD_NONE, 32'h1111_1111, 32'd0);
    step();
    drive(1'b1, 1'b0, 2'b01, MD_NONE, 32'h1111_1111, 32'd0);
    step();
    mdl_hi = 32'h1111_1111;
    mdl_lo = 32'h1111_1111;
    drive(1'b1, 1'b0, 2'b11, MD_DIV, $urandom, 32'($urandom_range(1, 50)));
    repeat (10) step();
    flush = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: stall=%b expected 0", stall); end
    step();
    drive(1'b1, 1'b0, 2'b10, MD_NONE, 32'hCAFE_BABE, 32'd0);
    n_checks++;
    if (stall !== 1'b0 || {hi_o, lo_o} !== {mdl_hi, mdl_lo}) begin
      n_fail++;
      $display("FAIL flush_nowrite: stall=%b hi/lo=%h/%h expected 0 %h/%h", stall, hi_o, lo_o, mdl_hi, mdl_lo);
    end
    step();
    drive_idle();
    mdl_hi = 32'hCAFE_BABE;
    n_checks++;
    if ({hi_o, lo_o} !== {mdl_hi, mdl_lo}) begin
      n_fail++;
      $display("FAIL flush_next_mthi: hi/lo=%h/%h expected %h/%h", hi_o, lo_o, mdl_hi, mdl_lo);
    end
    repeat (30) step();
    n_checks++;
    if ({hi_o, lo_o} !== {mdl_hi, mdl_lo} || div_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_late_write: hi/lo=%h/%h busy=%b expected %h/%h 0", hi_o, lo_o, div_busy, mdl_hi, mdl_lo);
    end
  endtask

  task automatic test_flush_done();
    int cyc;
    drive(1'b1, 1'b0, 2'b11, MD_DIVU, $urandom, 32'($urandom_range(1, 50)));
    cyc = 0;
    while (stall === 1'b1 && cyc < 100) begin
      cyc++;
      step();
      #1;
    end
    flush = 1'b1;
    #1;
    step();
    drive_idle();
    n_checks++;
    if ({hi_o, lo_o} !== {mdl_hi, mdl_lo} || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done: hi/lo=%h/%h stall=%b expected %h/%h 0", hi_o, lo_o, stall, mdl_hi, mdl_lo);
    end
  endtask

  task automatic test_reset_mid_div();
    drive(1'b1, 1'b0, 2'b10, MD_NONE, 32'h5555_AAAA, 32'd0);
    step();
    drive(1'b1, 1'b0, 2'b11, MD_DIV, $urandom, 32'($urandom_range(1, 50)));
    repeat (20) step();
    resetn = 1'b0;
    drive_idle();
    step();
    mdl_hi = '0;
    mdl_lo = '0;
    n_checks++;
    if ({hi_o, lo_o} !== 64'd0 || stall !== 1'b0 || div_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_div: hi/lo=%h/%h stall=%b busy=%b expected 0/0 0 0", hi_o, lo_o, stall, div_busy);
    end
    resetn = 1'b1;
    repeat (20) step();
    n_checks++;
    if ({hi_o, lo_o} !== 64'd0 || div_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort_write: hi/lo=%h/%h busy=%b expected 0/0 0", hi_o, lo_o, div_busy);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mt();
    test_mult();
    test_random_ops();
    test_div();
    test_flush_run();
    test_flush_done();
    test_reset_mid_div();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_md_unit.md
# hilo_md_unit

Execute-stage consumer of the main decoder's `hilo_we` and multiply/divide control. Owns the architectural HI/LO registers and performs MTHI/MTLO writes, single-cycle MULT/MULTU and an iterative 32-step DIV/DIVU. While a divide runs it stalls the pipeline. HI/LO are read by MFHI/MFLO in the same stage.

## Interface
Parameters:
- `DIV_STEPS`, 32: quotient bits produced, one per cycle; fixed at 32 for MIPS32.

Ports:
- `clk` in 1: rising-edge clock.
- `resetn` in 1: synchronous, active-low reset.
- `flush` in 1: kill the E-stage instruction and abort any running divide.
- `op_valid` in 1: E-stage instruction valid.
- `hilo_we` in 2: from the decoder, `{hi_we, lo_we}`.
- `md_op` in 3: `MD_NONE`, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU` (package encodings).
- `src_a` in 32: rs value (dividend / multiplicand / MT data).
- `src_b` in 32: rt value (divisor / multiplier).
- `stall` out 1: hold IF/ID/E; combinational.
- `hi_o` out 32: registered HI.
- `lo_o` out 32: registered LO.
- `div_busy` out 1: registered; high in `DIV_RUN`.

## Operation
- **Reset** (`resetn`=0 at edge): HI=0, LO=0, state `IDLE`, iteration counter 0. `stall`=0 and `div_busy`=0.
- **Accept**: an operation is accepted only when `op_valid`=1, `flush`=0 and state is `IDLE`.
- **Write selection** (`IDLE`, accepted):
  - `hilo_we`=2'b10: HI←`src_a`.
  - `hilo_we`=2'b01: LO←`src_a`.
  - `hilo_we`=2'b11 with `MD_MULT`/`MD_MULTU`: `{HI,LO}`←signed/unsigned 64-bit product, written at the same edge.
  - `hilo_we`=2'b11 with `MD_DIV`/`MD_DIVU`: start a divide.
  - Any other combination (including `hilo_we`=2'b00): no write.
- **FSM**:
  - `IDLE`: on divide start, latch |dividend|, |divisor|, quotient sign and remainder sign (signed op only). Assert `stall` in this cycle. Go to `DIV_RUN`.
  - `DIV_RUN`: one restoring shift-subtract step per cycle, counter 0..31. `stall`=1. After step 31, go to `DIV_DONE`.
  - `DIV_DONE`: apply signs, write LO=quotient and HI=remainder, `stall`=0. The held instruction retires this cycle. Go to `IDLE` unconditionally; do not restart even though the same instruction is still presented.
- **Arithmetic**:
  - Remainder sign follows the dividend.
  - Quotient is negative iff operand signs differ (signed op only).
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
  - Divisor 0 gives LO=0xFFFFFFFF, HI=`src_a`, with normal latency.
- **Flush**:
  - In `IDLE`: nothing is accepted.
  - In `DIV_RUN` or `DIV_DONE`: go to `IDLE` next cycle with no HI/LO write; `stall` is 0 in the flush cycle.
- **Reset mid-divide**: aborts with no write; HI/LO return to 0.
- **Read**: `hi_o`/`lo_o` are register outputs only. MFHI following MT/MULT sees the new value next cycle, so no forwarding is needed.

## Timing
- MT*, MULT, MULTU: zero stall; HI/LO are updated at the end of the accept cycle.
- DIV/DIVU (accept = cycle 0):
  - `stall`=1 in cycles 0–32.
  - `DIV_DONE` in cycle 33: `stall`=0 and the write lands at the end of cycle 33.
  - Next accept is possible in cycle 34.
- `div_busy`: high in cycles 1–32.
- `stall` = (`IDLE` & accepted divide) | `DIV_RUN`.

## Configuration
- `HILO_DIV_EN` defined:
  - Divider, `DIV_RUN`/`DIV_DONE` states and counter are present, as above.
- `HILO_DIV_EN` undefined:
  - No divider hardware.
  - DIV/DIVU perform no HI/LO write.
  - `stall` is tied to 0 and `div_busy` is tied to 0.
  - MT and MULT behaviour is unchanged.

## Structure
- Shared package `hilo_pkg`:
  - `md_op` encodings: `MD_NONE`=0, `MD_MULT`=1, `MD_MULTU`=2, `MD_DIV`=3, `MD_DIVU`=4.
  - FSM state encodings: `IDLE`, `DIV_RUN`, `DIV_DONE`.
- Sub-module `div_iter`: holds the magnitude shift-subtract datapath and counter, with start/abort/done handshake. It is instantiated only under `HILO_DIV_EN`. Sign fix-up and HI/LO registers stay in the top module.

## Test plan
- Reset, then MTHI 0x12345678 followed by MTLO 0x9ABCDEF0 → `hi_o`=0x12345678, `lo_o`=0x9ABCDEF0, `stall` never asserted.
- MULT 0xFFFFFFFE × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU of the same operands → HI=0x00000002, LO=0xFFFFFFFA. Both written in one cycle.
- DIV −7 / 2 → `stall` high for exactly 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=14, HI=2. No restart in `DIV_DONE`.
- Edge divides:
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 5 / 0 → LO=0xFFFFFFFF, HI=5 after 34 cycles.
- `flush` at cycle 10 of a divide (HI=LO=0x11111111 beforehand) → `stall`=0 in that cycle, HI/LO unchanged, and a new MTHI accepted next cycle.
- `resetn`=0 at cycle 20 of a divide → HI=LO=0, `IDLE`, `stall`=0 after the edge.
